// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: tear-free double-buffered hex display.
// Optional leading-zero blanking with `define SEG_SCAN_LZB_EN.
module seg_scan_driver #(
  parameter int CLK_HZ     = 50000000,
  parameter int REFRESH_HZ = 60,
  parameter int DIGITS     = 4,
  parameter int BLANK_CYC  = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic                  load_ack,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     n_digit,
  output logic                  frame_done
);

  localparam int DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  state;
  logic                  state_nxt;

  logic [4*DIGITS-1:0]   live_val;
  logic [DIGITS-1:0]     live_dp;
  logic [4*DIGITS-1:0]   live_val_nxt;
  logic [DIGITS-1:0]     live_dp_nxt;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_flag;

  logic                  slot_end;
  logic                  frame_end;
  logic                  commit;

  logic [DIGITS-1:0]     lz;
  logic [3:0]            nib;
  logic                  dpb;
  logic                  blk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign commit    = frame_end && (load || pend_flag);

  always_comb begin
    cnt_nxt = slot_end ? '0 : cnt + CW'(1);
    idx_nxt = idx;
    if (slot_end)
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
  end

  // A load landing on the boundary edge bypasses pending and goes live.
  always_comb begin
    live_val_nxt = live_val;
    live_dp_nxt  = live_dp;
    if (commit) begin
      live_val_nxt = load ? value : pend_val;
      live_dp_nxt  = load ? dp    : pend_dp;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_BLANK): begin
        if (cnt_nxt == CNT_SHOW)
          state_nxt = ST_SHOW;
      end
      (state == ST_SHOW): begin
        if (slot_end && (BLANK_CYC != 0))
          state_nxt = ST_BLANK;
      end
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run && (live_val_nxt[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
    lz[0] = 1'b0;
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    nib = 4'h0;
    dpb = 1'b0;
    blk = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib = live_val_nxt[4*i +: 4];
        dpb = live_dp_nxt[i];
        blk = lz[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_val  <= '0;
      live_dp   <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else begin
      live_val <= live_val_nxt;
      live_dp  <= live_dp_nxt;
      if (load && !frame_end) begin
        pend_val  <= value;
        pend_dp   <= dp;
        pend_flag <= 1'b1;
      end else if (frame_end) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // Outputs follow the next-state position so enable and pattern align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_digit    <= '1;
      seg        <= 7'h7F;
      seg_dp     <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      load_ack   <= commit;
      frame_done <= frame_end;
      if (state_nxt == ST_SHOW) begin
        n_digit <= ~(DIGITS'(1) << idx_nxt);
        seg     <= blk ? 7'h7F : ~hex7(nib);
        seg_dp  <= ~dpb;
      end else begin
        n_digit <= '1;
        seg     <= 7'h7F;
        seg_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIV=20, 4 digits, 2 blank cycles).
// Leading-zero blanking vectors run when SEG_SCAN_LZB_EN is defined.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        load_ack;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  n_digit;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .CLK_HZ(8000),
    .REFRESH_HZ(100),
    .DIGITS(4),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .dp(dp),
    .load(load),
    .load_ack(load_ack),
    .seg(seg),
    .seg_dp(seg_dp),
    .n_digit(n_digit),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    int          idx;
    int          cnt;
    logic [3:0]  nd;
    logic [6:0]  sg;
    logic        sdp;
  } vec_t;

  vec_t vt[13];

  int   checks = 0;
  int   errors = 0;
  int   tcnt;
  int   tidx;
  int   acks;
  logic mpend;
  logic last_bnd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    tcnt     = 0;
    tidx     = 0;
    mpend    = 1'b0;
    last_bnd = 1'b0;
  endtask

  // One clock; frame_done and load_ack are checked on every cycle.
  task automatic step();
    logic bnd;
    logic ack_e;
    bnd   = (tidx == 3) && (tcnt == 19);
    ack_e = bnd && (mpend || load);
    @(posedge clk);
    #1;
    if (bnd) mpend = 1'b0;
    else if (load) mpend = 1'b1;
    if (tcnt == 19) begin
      tcnt = 0;
      tidx = (tidx == 3) ? 0 : tidx + 1;
    end else begin
      tcnt++;
    end
    last_bnd = bnd;
    chk("frame_done", frame_done, bnd);
    chk("load_ack", load_ack, ack_e);
    if (load_ack) acks++;
  endtask

  task automatic goto_pos(int i, int c);
    int n;
    n = 0;
    while (!(tidx == i && tcnt == c) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL goto: timeout at %0d/%0d", tidx, tcnt);
    end
  endtask

  task automatic next_frame(int i, int c);
    int n;
    step();
    n = 0;
    while (!last_bnd && n < 100) begin
      step();
      n++;
    end
    goto_pos(i, c);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic show(string nm, logic [3:0] nd,
                      logic [6:0] sg, logic sdp);
    chk({nm, " n_digit"}, n_digit, nd);
    chk({nm, " seg"}, seg, sg);
    chk({nm, " seg_dp"}, seg_dp, sdp);
  endtask

  initial begin
    int n;
    vt[0]  = '{16'h4321, 4'b0000, 3, 5,  4'b0111, 7'h19, 1'b1};
    vt[1]  = '{16'h4321, 4'b0000, 0, 2,  4'b1110, 7'h79, 1'b1};
    vt[2]  = '{16'h89AB, 4'b0010, 1, 10, 4'b1101, 7'h08, 1'b0};
    vt[3]  = '{16'h89AB, 4'b0010, 2, 19, 4'b1011, 7'h10, 1'b1};
    vt[4]  = '{16'hCDEF, 4'b1000, 3, 7,  4'b0111, 7'h46, 1'b0};
    vt[5]  = '{16'hCDEF, 4'b1000, 0, 1,  4'b1111, 7'h7F, 1'b1};
    vt[6]  = '{16'hCDEF, 4'b1000, 0, 2,  4'b1110, 7'h0E, 1'b1};
    vt[7]  = '{16'h7B6D, 4'b0001, 1, 3,  4'b1101, 7'h02, 1'b1};
    vt[8]  = '{16'h7B6D, 4'b0001, 0, 4,  4'b1110, 7'h21, 1'b0};
    vt[9]  = '{16'h7B6D, 4'b0001, 2, 9,  4'b1011, 7'h03, 1'b1};
    vt[10] = '{16'h7B6D, 4'b0001, 3, 12, 4'b0111, 7'h78, 1'b1};
    vt[11] = '{16'h8E25, 4'b0000, 1, 6,  4'b1101, 7'h24, 1'b1};
    vt[12] = '{16'h8E25, 4'b0000, 2, 6,  4'b1011, 7'h06, 1'b1};

    rst_n = 1'b0;
    value = 16'h0;
    dp    = 4'h0;
    load  = 1'b0;
    acks  = 0;
    model_reset();

    #12;
    show("in_reset", 4'b1111, 7'h7F, 1'b1);
    chk("in_reset load_ack", load_ack, 1'b0);
    chk("in_reset frame_done", frame_done, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    goto_pos(0, 1);
    show("post_rst blank", 4'b1111, 7'h7F, 1'b1);
    goto_pos(0, 2);
    show("post_rst d0", 4'b1110, 7'h40, 1'b1);

    n = 0;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    n = 0;
    step();
    n++;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    chk("frame_period", n, 80);

    acks = 0;
    goto_pos(1, 5);
    do_load(16'h4321, 4'b0000);
    goto_pos(3, 5);
    show("tear_free d3", 4'b0111, 7'h40, 1'b1);
    chk("early_ack", acks, 0);
    next_frame(3, 5);
    show("load4321 d3", 4'b0111, 7'h19, 1'b1);
    chk("ack_4321", acks, 1);

    acks = 0;
    goto_pos(1, 5);
    do_load(16'h1111, 4'b0000);
    goto_pos(2, 3);
    do_load(16'hABCD, 4'b0000);
    next_frame(3, 5);
    show("last_wins d3", 4'b0111, 7'h08, 1'b1);
    next_frame(3, 5);
    chk("two_load acks", acks, 1);

    goto_pos(3, 19);
    value = 16'h2468;
    dp    = 4'b0000;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("bnd_load ack", load_ack, 1'b1);
    chk("bnd_load fd", frame_done, 1'b1);
    goto_pos(0, 2);
    show("bnd_load d0", 4'b1110, 7'h00, 1'b1);

    for (int k = 0; k < 13; k++) begin
      do_load(vt[k].val, vt[k].dpv);
      next_frame(vt[k].idx, vt[k].cnt);
      show($sformatf("vec%0d", k), vt[k].nd, vt[k].sg, vt[k].sdp);
    end

`ifdef SEG_SCAN_LZB_EN
    do_load(16'h0070, 4'b1000);
    next_frame(3, 5);
    show("lzb d3", 4'b0111, 7'h7F, 1'b0);
    next_frame(0, 5);
    show("lzb d0", 4'b1110, 7'h40, 1'b1);
    goto_pos(1, 5);
    show("lzb d1", 4'b1101, 7'h78, 1'b1);
    goto_pos(2, 5);
    show("lzb d2", 4'b1011, 7'h7F, 1'b1);
`endif

    goto_pos(1, 4);
    do_load(16'h9999, 4'b1111);
    goto_pos(2, 10);
    chk("pre_rst n_digit", n_digit, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    show("async_rst", 4'b1111, 7'h7F, 1'b1);
    chk("async_rst load_ack", load_ack, 1'b0);
    chk("async_rst frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    acks = 0;
    goto_pos(0, 2);
    show("rst2 d0", 4'b1110, 7'h40, 1'b1);
    next_frame(0, 2);
    show("discard d0", 4'b1110, 7'h40, 1'b1);
    chk("discard acks", acks, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter REFRESH_HZ, default 60, full-frame refresh rate in Hz.
REQ-003 SHALL have parameter DIGITS, default 4, digit count; legal range 1..8.
REQ-004 SHALL have parameter BLANK_CYC, default 500, anti-ghost blanking cycles per digit slot; SHALL be less than DIV.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port value, input, 4*DIGITS bits, hex nibbles; nibble 0 maps to digit 0 (rightmost).
REQ-008 SHALL have port dp, input, DIGITS bits, decimal-point request per digit.
REQ-009 SHALL have port load, input, 1 bit, single-cycle strobe capturing value and dp.
REQ-010 SHALL have port load_ack, output, 1 bit, one-cycle pulse when captured data goes live.
REQ-011 SHALL have port seg, output, 7 bits, active-low segments; bit0=a … bit6=g.
REQ-012 SHALL have port seg_dp, output, 1 bit, active-low decimal point.
REQ-013 SHALL have port n_digit, output, DIGITS bits, active-low digit enables.
REQ-014 SHALL have port frame_done, output, 1 bit, one-cycle pulse at the end of each full scan.

Function
REQ-015 SHALL derive DIV = CLK_HZ / (REFRESH_HZ*DIGITS) cycles per digit slot, computed at elaboration.
REQ-016 SHALL use a slot counter 0..DIV-1 that wraps to 0 and advances the scan index 0..DIGITS-1, wrapping to 0.
REQ-017 SHALL run a two-state FSM per slot: BLANK for counts 0..BLANK_CYC-1, then SHOW for counts BLANK_CYC..DIV-1.
REQ-018 In BLANK, n_digit SHALL be all ones, seg SHALL be 7'h7F and seg_dp 1.
REQ-019 In SHOW, exactly one n_digit bit (the scan index) SHALL be 0, with seg/seg_dp driven from the live nibble/dp of that digit.
REQ-020 Outputs SHALL be registered; digit enable and segment pattern change on the same edge (no skew cycle).
REQ-021 Decode (active-high gfedcba before inversion) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 load SHALL copy value/dp into a pending register and set a pending flag on the same edge; later loads before the frame boundary SHALL overwrite pending (last wins).
REQ-023 At the frame boundary (scan index DIGITS-1, count DIV-1), a set pending flag SHALL transfer pending to live, clear the flag and pulse load_ack the next cycle.
REQ-024 If load coincides with the frame boundary, the newly loaded data SHALL go live at that boundary, with a single load_ack pulse.
REQ-025 Live data SHALL never change mid-frame (tear-free).
REQ-026 frame_done SHALL pulse the cycle after the frame boundary, coincident with any load_ack.

Reset
REQ-027 On rst_n low, outputs SHALL immediately become: n_digit all ones, seg 7'h7F, seg_dp 1, load_ack 0, frame_done 0.
REQ-028 On rst_n low, counter, scan index, FSM (BLANK), live, pending and pending flag SHALL clear to 0.
REQ-029 After rst_n release, the first SHOW slot SHALL be digit 0 displaying "0"; a load pending at reset SHALL be discarded.

Configuration
REQ-030 With macro SEG_SCAN_LZB_EN defined, leading-zero blanking SHALL apply: a digit SHALL be blanked (seg 7'h7F) if it and all higher-index live nibbles are 0, except digit 0 is never blanked.
REQ-031 With SEG_SCAN_LZB_EN defined, blanked digits SHALL still show dp when requested, and n_digit timing SHALL be unchanged.
REQ-032 Without SEG_SCAN_LZB_EN, every digit SHALL be decoded per REQ-021.

Verification (CLK_HZ=8000, REFRESH_HZ=100, DIGITS=4, BLANK_CYC=2, so DIV=20)
REQ-033 Reset release, no load: SHOW digit 0 at count 2 gives n_digit=1110, seg=7'h40; frame_done every 80 cycles.
REQ-034 Load value=16'h4321 mid-frame: load_ack and first 4321 display only after the frame boundary; digit 3 shows seg=7'h19.
REQ-035 Two loads, 16'h1111 then 16'hABCD, in one frame: one load_ack; digit 3 shows seg=7'h08 (A).
REQ-036 Load asserted exactly at the frame boundary: data live the next slot, load_ack and frame_done on the same cycle.
REQ-037 With SEG_SCAN_LZB_EN, value=16'h0070, dp=4'b1000: digits 3 and 2 blank, digit 3 seg_dp=0, digit 0 shows 7'h40.
REQ-038 Assert rst_n low during SHOW of digit 2: n_digit=1111 and seg=7'h7F in the same cycle with no clock edge.
